// File: rtl/dff_pipe.sv
// dff_pipe: collapsing register pipeline with valid/ready at both ends,
// occupancy count and synchronous flush. Each stage advances whenever the
// stage ahead of it is empty or itself advancing.

// One pipeline stage: data + valid register with load-on-advance.
module dff_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             flush,
  input  logic             d_vld,
  input  logic [WIDTH-1:0] d_data,
  output logic             q_vld,
  output logic [WIDTH-1:0] q_data
);

  // Load on advance; flush drops the valid bit but leaves the data alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_vld  <= 1'b0;
      q_data <= '0;
    end else begin
      if (flush)    q_vld <= 1'b0;
      else if (adv) q_vld <= d_vld;
      if (adv && !flush) q_data <= d_data;
    end
  end

endmodule

module dff_pipe #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 3,
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0]            vld_pipe;
  logic [DEPTH-1:0][WIDTH-1:0] dat_pipe;
  logic [DEPTH-1:0]            adv;
  logic                        in_fire;
  logic                        out_fire;

  // Ready chain: a stage may move when it is empty or the next stage moves.
  always_comb begin
    adv            = '0;
    adv[DEPTH-1]   = !vld_pipe[DEPTH-1] | out_ready;
    for (int i = DEPTH-2; i >= 0; i--)
      adv[i] = !vld_pipe[i] | adv[i+1];
  end

  assign in_ready  = adv[0] & !flush & rst_n;
  assign in_fire   = in_valid & in_ready;
  assign out_valid = vld_pipe[DEPTH-1];
  assign out_data  = dat_pipe[DEPTH-1];
  assign out_fire  = out_valid & out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stg
    if (i == 0) begin : g_head
      dff_pipe_stage #(.WIDTH(WIDTH)) u_stg (
        .clk    (clk),
        .rst_n  (rst_n),
        .adv    (adv[i]),
        .flush  (flush),
        .d_vld  (in_fire),
        .d_data (in_data),
        .q_vld  (vld_pipe[i]),
        .q_data (dat_pipe[i])
      );
    end else begin : g_body
      dff_pipe_stage #(.WIDTH(WIDTH)) u_stg (
        .clk    (clk),
        .rst_n  (rst_n),
        .adv    (adv[i]),
        .flush  (flush),
        .d_vld  (vld_pipe[i-1]),
        .d_data (dat_pipe[i-1]),
        .q_vld  (vld_pipe[i]),
        .q_data (dat_pipe[i])
      );
    end
  end

  // Occupancy tracks accepts minus emits; flush empties the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     count <= '0;
    else if (flush) count <= '0;
    else            count <= count + CW'(in_fire) - CW'(out_fire);
  end

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe (WIDTH=8, DEPTH=3): directed vectors plus a random
// soak, with a queue scoreboard holding the items believed to be in the pipe.
module tb_dff_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [CW-1:0]    count;

  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] exp_q[$];

  dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard feed: record every accepted item (inputs are stable here).
  always @(negedge clk) begin
    #2;
    if (in_valid && in_ready) exp_q.push_back(in_data);
  end

  // Monitor: occupancy vs scoreboard, in-order output check, flush drop.
  always @(negedge clk) begin
    logic [WIDTH-1:0] e;
    chk("count_vs_model", 32'(count), 32'(exp_q.size()));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL out_unexpected act=%0h exp=none t=%0t", out_data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e));
      end
    end
    if (flush) exp_q.delete();
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready",  32'(in_ready),  0);
    chk("rst_count",     32'(count),     0);
    tick(); tick();
    rst_n = 1'b1;

    // Back-to-back stream, 3-cycle latency to first presentation.
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h11;
    #1 chk("t2_in_ready", 32'(in_ready), 1);
    tick(); chk("t2_lat1", 32'(out_valid), 0); in_data = 8'h22;
    tick(); chk("t2_lat2", 32'(out_valid), 0); in_data = 8'h33;
    tick(); chk("t2_first_valid", 32'(out_valid), 1);
    chk("t2_first_data", 32'(out_data), 32'h11);
    chk("t2_count", 32'(count), 3);
    in_valid = 1'b0;
    tick(); chk("t2_second", 32'(out_data), 32'h22);
    tick(); chk("t2_third",  32'(out_data), 32'h33);
    tick(); chk("t2_empty",  32'(out_valid), 0);

    // Stall: 3 accepted, 4th held until out_ready rises.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = 8'(i);
      tick();
    end
    in_data = 8'h04;
    #1 chk("t3_full_ready", 32'(in_ready), 0);
    chk("t3_full_count", 32'(count), 3);
    tick(); chk("t3_hold_ready", 32'(in_ready), 0);
    out_ready = 1'b1;
    #1 chk("t3_comb_ready", 32'(in_ready), 1);
    tick(); chk("t3_count_steady", 32'(count), 3);
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("t3_drained", 32'(count), 0);

    // Collapse: A0 reaches the last stage, B0 packs in behind it.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA0;
    tick(); in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    chk("t4_a0_at_out", 32'(out_data), 32'hA0);
    in_valid = 1'b1; in_data = 8'hB0;
    tick(); in_valid = 1'b0;
    tick(); chk("t4_count2", 32'(count), 2);
    in_valid = 1'b1; in_data = 8'hC0;
    #1 chk("t4_ready_2", 32'(in_ready), 1);
    tick(); chk("t4_count3", 32'(count), 3);
    in_data = 8'hD0;
    #1 chk("t4_full_ready", 32'(in_ready), 0);

    // Flush while full: head item transfers, input refused, pipe empties.
    flush = 1'b1; out_ready = 1'b1;
    #1 chk("t5_flush_ready", 32'(in_ready), 0);
    chk("t5_out_valid", 32'(out_valid), 1);
    chk("t5_out_data", 32'(out_data), 32'hA0);
    tick(); flush = 1'b0; in_valid = 1'b0;
    chk("t5_count0", 32'(count), 0);
    chk("t5_out_valid0", 32'(out_valid), 0);
    tick(); tick();
    chk("t5_no_leak", 32'(out_valid), 0);

    // Async reset with items in flight, between edges.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'h5A; tick();
    in_data = 8'h5B; tick();
    in_data = 8'h5C; tick();
    in_valid = 1'b0;
    #2;
    chk("t1_pre_count", 32'(count), 3);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t1_out_valid", 32'(out_valid), 0);
    chk("t1_out_data",  32'(out_data),  0);
    chk("t1_count",     32'(count),     0);
    chk("t1_in_ready",  32'(in_ready),  0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    #1 chk("t1_first_accept", 32'(in_ready), 1);
    tick(); in_valid = 1'b0;
    tick(); tick();
    chk("t1_post_data", 32'(out_data), 32'h77);
    tick();

    // Random soak: in-order, no loss or duplication, occasional flush.
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(2) != 0);
      flush     = ($urandom_range(63) == 0);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    chk("drain_count", 32'(count), 0);
    chk("drain_model", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
